// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbitration control stage.
package arb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } arb_st_e;

    // Widest requester vector the rotation helper supports.
    localparam int ARB_MAX_W = 32;

    // Rotates the low w bits of g up by one position, wrapping the top bit
    // back to bit 0. Bits at or above w are returned as zero.
    function automatic logic [ARB_MAX_W-1:0] rot1(input logic [ARB_MAX_W-1:0] g,
                                                 input int unsigned         w);
        logic [ARB_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ARB_MAX_W; i++) begin
            if (i < int'(w)) begin
                r[(i == int'(w) - 1) ? 0 : ((i + 1) % ARB_MAX_W)] = g[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_fp.sv
// Fixed-priority arbiter: scans upward from the one-hot priority position,
// wrapping, and grants the first valid requester. Purely combinational.
module arb_fp #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] v_vld,
    input  logic [WIDTH-1:0] v_priority,
    output logic [WIDTH-1:0] v_grant
);

    // Locate the priority position, then pick the first valid bit from there.
    always_comb begin
        int start;
        int idx;
        logic found;
        start   = 0;
        idx     = 0;
        found   = 1'b0;
        v_grant = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (v_priority[i]) begin
                start = i;
            end
        end
        for (int k = 0; k < int'(WIDTH); k++) begin
            idx = (start + k) % int'(WIDTH);
            if (!found && v_vld[idx]) begin
                v_grant[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_rr_ctrl.sv
// Round-robin control stage in front of arb_fp: rotates priority after each
// completed packet and holds the grant on one requester for multi-beat packets.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | arb_fp picks among all requesters starting at prio_q
//   ST_LOCK  | mid-packet; grant pinned to lock_q until last beat or timeout
module arb_rr_ctrl
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] v_req,
    input  logic [WIDTH-1:0] v_last,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] v_vld_o,
    output logic [WIDTH-1:0] v_priority_o,
    input  logic [WIDTH-1:0] v_grant_i,
    output logic [WIDTH-1:0] v_gnt,
    output logic             fire,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             err_timeout
);

    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  BEAT_MAX  = '1;

    arb_st_e             state_q, state_d;
    logic [WIDTH-1:0]    prio_q, prio_d;
    logic [WIDTH-1:0]    lock_q, lock_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                err_timeout_q, err_timeout_d;
    // beat_cnt shows the final count for one cycle after a packet ends, then clears.
    logic                clr_pend_q, clr_pend_d;

    logic                lst;
    logic                lock_req;
    logic                timeout_hit;
    logic [WIDTH-1:0]    rot_in;
    logic [ARB_MAX_W-1:0] rot_full;
    logic [WIDTH-1:0]    prio_rot;

    // Datapath toward arb_fp and the effective grant back to requesters.
    always_comb begin
        v_vld_o      = v_req;
        v_priority_o = prio_q;
        v_gnt        = v_grant_i & v_req;
        if (state_q == ST_LOCK) begin
            v_vld_o      = v_req & lock_q;
            v_priority_o = lock_q;
            v_gnt        = lock_q & v_req;
        end
        fire     = out_rdy & (|v_gnt);
        lst      = fire & (|(v_gnt & v_last));
        lock_req = |(v_req & lock_q);
    end

    // Next priority after serving a requester; never allowed to go zero.
    always_comb begin
        rot_in   = (state_q == ST_LOCK) ? lock_q : v_gnt;
        rot_full = rot1(ARB_MAX_W'(rot_in), WIDTH);
        prio_rot = (rot_full == '0) ? WIDTH'(1) : rot_full[WIDTH-1:0];
    end

    // FSM, priority/lock registers and the lock idle timer.
    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        lock_d        = lock_q;
        idle_cnt_d    = idle_cnt_q;
        err_timeout_d = 1'b0;
        timeout_hit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (fire && lst) begin
                    prio_d = prio_rot;
                end else if (fire) begin
                    lock_d  = v_gnt;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (fire && lst) begin
                    prio_d     = prio_rot;
                    lock_d     = '0;
                    idle_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else if (lock_req) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    prio_d        = prio_rot;
                    lock_d        = '0;
                    idle_cnt_d    = '0;
                    err_timeout_d = 1'b1;
                    timeout_hit   = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating beat counter; a first beat arriving in the clear cycle counts as 1.
    always_comb begin
        logic [CNT_W-1:0] base;
        base       = clr_pend_q ? '0 : beat_cnt_q;
        beat_cnt_d = base;
        if (fire && (base != BEAT_MAX)) begin
            beat_cnt_d = base + CNT_W'(1);
        end
        clr_pend_d = (fire && lst) || timeout_hit;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            prio_q        <= WIDTH'(1);
            lock_q        <= '0;
            idle_cnt_q    <= '0;
            beat_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
            clr_pend_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            lock_q        <= lock_d;
            idle_cnt_q    <= idle_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            err_timeout_q <= err_timeout_d;
            clr_pend_q    <= clr_pend_d;
        end
    end

    assign busy        = (state_q == ST_LOCK);
    assign beat_cnt    = beat_cnt_q;
    assign err_timeout = err_timeout_q;

endmodule
